// File: rtl/fp_add_pkg.sv
// Shared types and constants for the single-precision adder datapath.
package fp_add_pkg;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;
    localparam int unsigned FP_W  = 1 + EXP_W + MAN_W;
    localparam int unsigned BIAS  = 127;
    localparam int unsigned ALN_W = MAN_W + 4;
    localparam logic [FP_W-1:0] QNAN = 32'h7FC00000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    typedef struct packed {
        logic             sign_big;
        logic             sign_small;
        logic [EXP_W-1:0] exp;
        logic [ALN_W-1:0] man_big;
        logic [ALN_W-1:0] man_small;
        logic             eff_sub;
        logic             special;
        logic [FP_W-1:0]  special_val;
    } aligned_t;

    function automatic logic is_nan(input fp32_t x);
        return (x.exp == '1) && (x.man != '0);
    endfunction

    function automatic logic is_inf(input fp32_t x);
        return (x.exp == '1) && (x.man == '0);
    endfunction

endpackage

// File: rtl/fp_add_align_if.sv
// Operand-in / aligned-out handshake bundle for fp_add_align.
interface fp_add_align_if;
    import fp_add_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [FP_W-1:0]  operand_1;
    logic [FP_W-1:0]  operand_2;
    logic             out_valid;
    logic             out_ready;
    logic             out_sign_big;
    logic             out_sign_small;
    logic [EXP_W-1:0] out_exp;
    logic [ALN_W-1:0] out_man_big;
    logic [ALN_W-1:0] out_man_small;
    logic             out_eff_sub;
    logic             out_special;
    logic [FP_W-1:0]  out_special_val;

    modport slave (
        input  in_valid, operand_1, operand_2, out_ready,
        output in_ready, out_valid, out_sign_big, out_sign_small, out_exp,
               out_man_big, out_man_small, out_eff_sub, out_special, out_special_val
    );

    modport master (
        output in_valid, operand_1, operand_2, out_ready,
        input  in_ready, out_valid, out_sign_big, out_sign_small, out_exp,
               out_man_big, out_man_small, out_eff_sub, out_special, out_special_val
    );

endinterface

// File: rtl/fp_shift_sticky.sv
// Combinational right shifter folding shifted-out bits into a sticky LSB.
module fp_shift_sticky
    import fp_add_pkg::*;
(
    input  logic [ALN_W-1:0] din,
    input  logic [EXP_W-1:0] shamt,
    output logic [ALN_W-1:0] dout
);

    logic lost;

    // Shift, then OR every discarded bit into bit 0; saturate to sticky-only at >= ALN_W.
    always_comb begin
        dout = '0;
        lost = 1'b0;
        if (shamt >= EXP_W'(ALN_W)) begin
            dout = {{(ALN_W-1){1'b0}}, |din};
        end else begin
            for (int unsigned i = 0; i < ALN_W; i++) begin
                if (i < {24'd0, shamt}) begin
                    lost = lost | din[i];
                end
            end
            dout    = din >> shamt;
            dout[0] = dout[0] | lost;
        end
    end

endmodule

// File: rtl/fp_add_align.sv
// Two-stage operand unpack/order/align front end for the binary32 adder.
// Optional build macro: FP_ALIGN_FTZ_EN flushes denormal operands to signed zero.
module fp_add_align
    import fp_add_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    fp_add_align_if.slave  bus
);

    fp32_t            op_a, op_b;
    logic [MAN_W-1:0] a_man, b_man;
    logic             a_hid, b_hid, a_big;
    logic [EXP_W-1:0] a_eexp, b_eexp;
    logic             spec;
    logic [FP_W-1:0]  spec_val;

    logic             s1_valid, s1_sign_big, s1_sign_small, s1_special;
    logic [EXP_W-1:0] s1_exp_big, s1_exp_diff;
    logic [MAN_W:0]   s1_sig_big, s1_sig_small;
    logic [FP_W-1:0]  s1_special_val;

    logic             s2_valid, s2_load;
    aligned_t         s2_q, s2_next;
    logic [ALN_W-1:0] man_small_aln;

    assign op_a = fp32_t'(bus.operand_1);
    assign op_b = fp32_t'(bus.operand_2);

    assign s2_load      = !s2_valid || bus.out_ready;
    assign bus.in_ready = !s1_valid || s2_load;

    // Unpack both operands, pick the larger magnitude and classify specials.
    always_comb begin
`ifdef FP_ALIGN_FTZ_EN
        a_man = (op_a.exp == '0) ? '0 : op_a.man;
        b_man = (op_b.exp == '0) ? '0 : op_b.man;
`else
        a_man = op_a.man;
        b_man = op_b.man;
`endif
        a_hid  = (op_a.exp != '0);
        b_hid  = (op_b.exp != '0);
        a_eexp = (op_a.exp == '0) ? EXP_W'(1) : op_a.exp;
        b_eexp = (op_b.exp == '0) ? EXP_W'(1) : op_b.exp;
        a_big  = {a_eexp, a_hid, a_man} >= {b_eexp, b_hid, b_man};

        spec     = is_nan(op_a) || is_nan(op_b) || is_inf(op_a) || is_inf(op_b);
        spec_val = '0;
        if (is_nan(op_a) || is_nan(op_b) ||
            (is_inf(op_a) && is_inf(op_b) && (op_a.sign != op_b.sign))) begin
            spec_val = QNAN;
        end else if (is_inf(op_a)) begin
            spec_val = {op_a.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (is_inf(op_b)) begin
            spec_val = {op_b.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
    end

    // Stage 1 register: ordered fields, exponent difference, special result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid       <= 1'b0;
            s1_sign_big    <= 1'b0;
            s1_sign_small  <= 1'b0;
            s1_exp_big     <= '0;
            s1_exp_diff    <= '0;
            s1_sig_big     <= '0;
            s1_sig_small   <= '0;
            s1_special     <= 1'b0;
            s1_special_val <= '0;
        end else if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sign_big    <= a_big ? op_a.sign : op_b.sign;
                s1_sign_small  <= a_big ? op_b.sign : op_a.sign;
                s1_exp_big     <= a_big ? a_eexp : b_eexp;
                s1_exp_diff    <= a_big ? (a_eexp - b_eexp) : (b_eexp - a_eexp);
                s1_sig_big     <= a_big ? {a_hid, a_man} : {b_hid, b_man};
                s1_sig_small   <= a_big ? {b_hid, b_man} : {a_hid, a_man};
                s1_special     <= spec;
                s1_special_val <= spec_val;
            end
        end
    end

    fp_shift_sticky u_shift (
        .din   ({s1_sig_small, 3'b000}),
        .shamt (s1_exp_diff),
        .dout  (man_small_aln)
    );

    // Assemble the aligned record handed to the adder core.
    always_comb begin
        s2_next             = '0;
        s2_next.sign_big    = s1_sign_big;
        s2_next.sign_small  = s1_sign_small;
        s2_next.exp         = s1_exp_big;
        s2_next.man_big     = {s1_sig_big, 3'b000};
        s2_next.man_small   = man_small_aln;
        s2_next.eff_sub     = s1_sign_big ^ s1_sign_small;
        s2_next.special     = s1_special;
        s2_next.special_val = s1_special_val;
    end

    // Stage 2 register: output holds while the adder core stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_q     <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_q <= s2_next;
            end
        end
    end

    assign bus.out_valid       = s2_valid;
    assign bus.out_sign_big    = s2_q.sign_big;
    assign bus.out_sign_small  = s2_q.sign_small;
    assign bus.out_exp         = s2_q.exp;
    assign bus.out_man_big     = s2_q.man_big;
    assign bus.out_man_small   = s2_q.man_small;
    assign bus.out_eff_sub     = s2_q.eff_sub;
    assign bus.out_special     = s2_q.special;
    assign bus.out_special_val = s2_q.special_val;

endmodule

// File: tb/tb_fp_add_align.sv
// Self-checking bench for fp_add_align: directed plan cases plus randomized pairs
// scored against an arithmetic reference model.
module tb_fp_add_align;

    typedef struct packed {
        logic        sb;
        logic        ss;
        logic [7:0]  e;
        logic [26:0] mb;
        logic [26:0] ms;
        logic        sub;
        logic        sp;
        logic [31:0] spv;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rand_ready = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_out = 0;
    res_t exp_q[$];
    res_t last_o;

    always #5 clk = ~clk;

    fp_add_align_if bus ();

    fp_add_align dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    endtask

    // Reference: magnitude = eff_exp * 2^24 + significand; alignment by integer division.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
        res_t r;
        int unsigned ea, eb, eea, eeb, ed;
        longint unsigned fa, fb, sa, sb, ka, kb, m, al;
        logic abig, nan_a, nan_b, inf_a, inf_b;
        ea = 32'(a[30:23]);
        eb = 32'(b[30:23]);
        fa = 64'(a[22:0]);
        fb = 64'(b[22:0]);
`ifdef FP_ALIGN_FTZ_EN
        if (ea == 0) fa = 0;
        if (eb == 0) fb = 0;
`endif
        sa  = (ea != 0) ? (64'd1 << 23) + fa : fa;
        sb  = (eb != 0) ? (64'd1 << 23) + fb : fb;
        eea = (ea == 0) ? 1 : ea;
        eeb = (eb == 0) ? 1 : eb;
        ka  = 64'(eea) * (64'd1 << 24) + sa;
        kb  = 64'(eeb) * (64'd1 << 24) + sb;
        abig = (ka >= kb);
        ed  = abig ? eea - eeb : eeb - eea;
        m   = (abig ? sb : sa) * 8;
        if (ed >= 27) al = (m != 0) ? 64'd1 : 64'd0;
        else al = (m >> ed) | (((m % (64'd1 << ed)) != 0) ? 64'd1 : 64'd0);
        r.sb  = abig ? a[31] : b[31];
        r.ss  = abig ? b[31] : a[31];
        r.e   = 8'(abig ? eea : eeb);
        r.mb  = 27'((abig ? sa : sb) * 8);
        r.ms  = 27'(al);
        r.sub = r.sb ^ r.ss;
        nan_a = (ea == 255) && (a[22:0] != 0);
        nan_b = (eb == 255) && (b[22:0] != 0);
        inf_a = (ea == 255) && (a[22:0] == 0);
        inf_b = (eb == 255) && (b[22:0] == 0);
        if (nan_a || nan_b || (inf_a && inf_b && (a[31] != b[31]))) begin
            r.sp = 1'b1; r.spv = 32'h7FC00000;
        end else if (inf_a) begin
            r.sp = 1'b1; r.spv = a;
        end else if (inf_b) begin
            r.sp = 1'b1; r.spv = b;
        end else begin
            r.sp = 1'b0; r.spv = 32'h0;
        end
        return r;
    endfunction

    function automatic res_t observe();
        res_t o;
        o.sb  = bus.out_sign_big;
        o.ss  = bus.out_sign_small;
        o.e   = bus.out_exp;
        o.mb  = bus.out_man_big;
        o.ms  = bus.out_man_small;
        o.sub = bus.out_eff_sub;
        o.sp  = bus.out_special;
        o.spv = bus.out_special_val;
        return o;
    endfunction

    function automatic logic [31:0] rnd_op(input logic [31:0] other);
        logic [31:0] v;
        logic [7:0]  e;
        v = $urandom;
        case ($urandom_range(0, 9))
            0: begin
                v[30:23] = 8'hFF;
                if ($urandom_range(0, 1) == 0) v[22:0] = '0;
            end
            1: v[30:23] = 8'h00;
            2, 3, 4: begin
                e = other[30:23] + 8'($urandom_range(0, 6)) - 8'd3;
                v[30:23] = e;
            end
            5: v[30:0] = other[30:0];
            default: ;
        endcase
        return v;
    endfunction

    // Scoreboard: sampled on the falling edge, away from the DUT's active edge.
    initial begin
        res_t held, cur, e;
        logic hold_pend;
        hold_pend = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    cur = observe();
                    chk("hold_valid", 64'(bus.out_valid), 64'd1);
                    chk("hold_lo", cur[63:0], held[63:0]);
                    chk("hold_hi", 64'(cur[97:64]), 64'(held[97:64]));
                end
                hold_pend = bus.out_valid && !bus.out_ready;
                held = observe();
                if (bus.in_valid && bus.in_ready)
                    exp_q.push_back(model(bus.operand_1, bus.operand_2));
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_out", 64'(bus.out_valid), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        cur = observe();
                        chk("sign_big", 64'(cur.sb), 64'(e.sb));
                        chk("sign_small", 64'(cur.ss), 64'(e.ss));
                        chk("exp", 64'(cur.e), 64'(e.e));
                        chk("man_big", 64'(cur.mb), 64'(e.mb));
                        chk("man_small", 64'(cur.ms), 64'(e.ms));
                        chk("eff_sub", 64'(cur.sub), 64'(e.sub));
                        chk("special", 64'(cur.sp), 64'(e.sp));
                        chk("special_val", 64'(cur.spv), 64'(e.spv));
                        last_o = cur;
                        n_out++;
                    end
                end
            end
        end
    end

    // Random backpressure generator.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int unsigned n;
        logic acc;
        n = 0;
        bus.in_valid  = 1'b1;
        bus.operand_1 = a;
        bus.operand_2 = b;
        forever begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 200) begin
                chk("send_timeout", 64'(bus.in_ready), 64'd1);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        rand_ready = 1'b0;
        bus.out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] bp_a[4];
        logic [31:0] bp_b[4];
        logic [31:0] ra, rb;
        int unsigned idx;
        int n_before;

        bus.in_valid  = 1'b0;
        bus.operand_1 = '0;
        bus.operand_2 = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_exp", 64'(bus.out_exp), 64'd0);
        chk("rst_man_big", 64'(bus.out_man_big), 64'd0);
        chk("rst_special_val", 64'(bus.out_special_val), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;

        // Basic add plus latency.
        send(32'h415B0000, 32'h3FC00000);
        @(negedge clk);
        chk("lat_c1_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("lat_c2_valid", 64'(bus.out_valid), 64'd1);
        drain();
        chk("t1_exp", 64'(last_o.e), 64'h82);
        chk("t1_man_big", 64'(last_o.mb), 64'h6D80000);
        chk("t1_man_small", 64'(last_o.ms), 64'h0C00000);
        chk("t1_eff_sub", 64'(last_o.sub), 64'd0);
        chk("t1_special", 64'(last_o.sp), 64'd0);

        // Sticky boundaries.
        send(32'h3F800000, 32'h33800000);
        drain();
        chk("diff24_man_small", 64'(last_o.ms), 64'h4);
        send(32'h3F800000, 32'h30800000);
        drain();
        chk("diff30_man_small", 64'(last_o.ms), 64'h1);

        // Specials.
        send(32'h7F800000, 32'hFF800000);
        drain();
        chk("infinf_special", 64'(last_o.sp), 64'd1);
        chk("infinf_val", 64'(last_o.spv), 64'h7FC00000);
        send(32'h7F800000, 32'h3F800000);
        drain();
        chk("inf_val", 64'(last_o.spv), 64'h7F800000);

        // Equal magnitude tie.
        send(32'h40400000, 32'hC0400000);
        drain();
        chk("tie_sign_big", 64'(last_o.sb), 64'd0);
        chk("tie_sign_small", 64'(last_o.ss), 64'd1);
        chk("tie_eff_sub", 64'(last_o.sub), 64'd1);
        chk("tie_man_big", 64'(last_o.mb), 64'h6000000);
        chk("tie_man_small", 64'(last_o.ms), 64'h6000000);

        // Denormal handling.
        send(32'h00000001, 32'h3F800000);
        drain();
`ifdef FP_ALIGN_FTZ_EN
        chk("ftz_man_small", 64'(last_o.ms), 64'h0);
`else
        chk("denorm_man_small", 64'(last_o.ms), 64'h1);
`endif

        // Backpressure: four pairs against a stalled core.
        bp_a[0] = 32'h3F800000; bp_b[0] = 32'h40000000;
        bp_a[1] = 32'hC1200000; bp_b[1] = 32'h3E800000;
        bp_a[2] = 32'h42C80000; bp_b[2] = 32'hC2C80000;
        bp_a[3] = 32'h00400000; bp_b[3] = 32'h80200000;
        n_before = n_out;
        bus.out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            bus.in_valid  = 1'b1;
            bus.operand_1 = bp_a[idx];
            bus.operand_2 = bp_b[idx];
            @(negedge clk);
            if (bus.in_ready) idx++;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("bp_accepts", 64'(idx), 64'd2);
        chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        while (idx < 4) begin
            send(bp_a[idx], bp_b[idx]);
            idx++;
        end
        drain();
        chk("bp_out_count", 64'(n_out - n_before), 64'd4);

        // Reset with both stages occupied.
        bus.out_ready = 1'b0;
        send(32'h3F800000, 32'h3F800000);
        send(32'h40800000, 32'hBF000000);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rstmid_in_ready", 64'(bus.in_ready), 64'd1);
        n_before = n_out;
        bus.out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("rstmid_no_stale", 64'(n_out - n_before), 64'd0);

        // Randomized pairs under random backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            rb = rnd_op(ra);
            if ($urandom_range(0, 1) == 0) send(ra, rb);
            else send(rb, ra);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

endmodule
